// File: rtl/player_motion.sv
// rtl/player_motion.sv - tilt-to-position integrator for the player square, one update per frame
module player_motion #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int DEADZONE = 16,
    parameter int SHIFT    = 4,
    parameter int VMAX     = 8
) (
    input  logic        clk_25mHz,
    input  logic        reset,
    input  logic        screenEnd,
    input  logic [11:0] tilt_x,
    input  logic [11:0] tilt_y,
    input  logic        tilt_valid,
    input  logic [31:0] game_state,
    output logic [31:0] accel_x,
    output logic [31:0] accel_y,
    output logic        moving
);

    typedef enum logic [1:0] {IDLE, CALC, APPLY} state_t;

    state_t            state, state_next;
    logic              se_d;
    logic [11:0]       hold_x, hold_y;
    logic [11:0]       snap_x, snap_y;
    logic              snap_start, snap_small;
    logic signed [4:0] vx, vy;
    logic [9:0]        pos_x;
    logic [8:0]        pos_y;
    logic              moving_q;
    logic              edge_det;

    logic signed [11:0] half, hi_x, hi_y, cand_x, cand_y, clamp_x, clamp_y;

    // -2048 has no positive twin in 12 bits, so its magnitude saturates to 2047.
    function automatic logic signed [4:0] calc_vel(input logic [11:0] t);
        logic [11:0] mag;
        logic [11:0] q;
        if (t == 12'h800)
            mag = 12'h7ff;
        else if (t[11])
            mag = -t;
        else
            mag = t;
        if (mag <= 12'(DEADZONE)) begin
            q = '0;
        end else begin
            q = (mag - 12'(DEADZONE)) >> SHIFT;
            if (q > 12'(VMAX))
                q = 12'(VMAX);
        end
        calc_vel = t[11] ? 5'(-q) : 5'(q);
    endfunction

    assign edge_det = screenEnd & ~se_d;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (edge_det) state_next = CALC;
            CALC:    state_next = APPLY;
            APPLY:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Half-size tracks the drawn square so its edges stay on screen.
    always_comb begin
        half    = snap_small ? 12'sd10 : 12'sd20;
        hi_x    = 12'(SCREEN_W - 1) - half;
        hi_y    = 12'(SCREEN_H - 1) - half;
        cand_x  = {2'b00, pos_x} + {{7{vx[4]}}, vx};
        cand_y  = {3'b000, pos_y} + {{7{vy[4]}}, vy};
        clamp_x = cand_x;
        clamp_y = cand_y;
        if (cand_x < half)
            clamp_x = half;
        else if (cand_x > hi_x)
            clamp_x = hi_x;
        if (cand_y < half)
            clamp_y = half;
        else if (cand_y > hi_y)
            clamp_y = hi_y;
    end

    always_ff @(posedge clk_25mHz) begin
        if (reset) begin
            state      <= IDLE;
            se_d       <= 1'b0;
            hold_x     <= '0;
            hold_y     <= '0;
            snap_x     <= '0;
            snap_y     <= '0;
            snap_start <= 1'b0;
            snap_small <= 1'b0;
            vx         <= '0;
            vy         <= '0;
            pos_x      <= 10'd320;
            pos_y      <= 9'd240;
            moving_q   <= 1'b0;
        end else begin
            state <= state_next;
            se_d  <= screenEnd;
            if (tilt_valid) begin
                hold_x <= tilt_x;
                hold_y <= tilt_y;
            end
            case (state)
                IDLE: begin
                    // Non-blocking reads give the pre-strobe hold value on a same-cycle tilt_valid.
                    if (edge_det) begin
                        snap_x     <= hold_x;
                        snap_y     <= hold_y;
                        snap_start <= (game_state == 32'd0);
                        snap_small <= (game_state == 32'd3);
                    end
                end
                CALC: begin
                    vx <= calc_vel(snap_x);
                    vy <= calc_vel(snap_y);
                end
                APPLY: begin
                    if (snap_start) begin
                        pos_x    <= 10'd320;
                        pos_y    <= 9'd240;
                        moving_q <= 1'b0;
                    end else begin
                        pos_x    <= clamp_x[9:0];
                        pos_y    <= clamp_y[8:0];
                        moving_q <= (vx != 5'sd0) || (vy != 5'sd0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign accel_x = {22'd0, pos_x};
    assign accel_y = {23'd0, pos_y};
    assign moving  = moving_q;

endmodule

// File: doc/player_motion.md
# player_motion

Converts raw accelerometer tilt samples into the player square's screen-centre coordinates, updating once per video frame. It sits directly upstream of the VGA controller and drives its `accel_x` / `accel_y` inputs. The update uses the same frame-boundary strobe (`screenEnd`) that the controller uses to latch those inputs. Tilt is dead-zoned, scaled into a per-frame velocity, integrated, and clamped so the drawn square never leaves the 640x480 screen.

## Interface
- `SCREEN_W`, 640: visible width in pixels.
- `SCREEN_H`, 480: visible height in pixels.
- `DEADZONE`, 16: tilt magnitude at or below which velocity is 0.
- `SHIFT`, 4: right-shift applied to (|tilt| − DEADZONE) to form the velocity.
- `VMAX`, 8: maximum velocity magnitude in pixels per frame.
- `clk_25mHz`  in  1: 25 MHz pixel clock; the only clock.
- `reset`  in  1: synchronous, active-high.
- `screenEnd`  in  1: frame-boundary level from the timing generator; its rising edge triggers an update.
- `tilt_x`  in  12: signed two's complement; positive = right.
- `tilt_y`  in  12: signed two's complement; positive = down.
- `tilt_valid`  in  1: single-cycle strobe; `tilt_x` / `tilt_y` are valid this cycle.
- `game_state`  in  32: 0 = start screen, 3 = small-square mode, any other value = normal play.
- `accel_x`  out  32: player centre x, zero-extended from 10 bits.
- `accel_y`  out  32: player centre y, zero-extended from 9 bits.
- `moving`  out  1: high when the last update applied a nonzero velocity on either axis.

## Operation
- **Sample hold**
  - On `tilt_valid`, `hold_x` and `hold_y` latch `tilt_x` and `tilt_y`.
  - Reset value of both hold registers is 0.
- **Edge detect**
  - `se_d` is `screenEnd` registered.
  - An update starts when `screenEnd`=1 and `se_d`=0, with the FSM in IDLE.
- **FSM states:** IDLE → CALC → APPLY → IDLE. Each non-IDLE state lasts exactly 1 cycle.
  - **IDLE:** on an edge, snapshot `hold_x`, `hold_y` and `game_state` into working registers, then go to CALC.
  - **CALC:** compute the velocity for each axis from the snapshot.
    - mag = |t|. −2048 saturates to 2047.
    - v = 0 if mag ≤ DEADZONE.
    - Otherwise v = sign(t) · min((mag − DEADZONE) >> SHIFT, VMAX).
  - **APPLY:** compute a 12-bit signed candidate p' = pos + v.
    - half = 10 if the snapshot game_state == 3, else 20. This matches the drawn square's half-size.
    - Clamp p' to [half, SCREEN_W−1−half] for x and [half, SCREEN_H−1−half] for y.
    - Write the clamped values to the position registers.
    - `moving` = (vx ≠ 0) | (vy ≠ 0).
- **Start screen:** if the snapshot game_state == 0, APPLY forces position to (320, 240) and `moving`=0.
- **Mode change:** a change 1→3 (or 3→1) takes effect at the next update. A position already outside the new bounds is clamped then.
- **Edges outside IDLE:** a `screenEnd` rising edge seen while in CALC or APPLY is dropped, not queued.
- **Late samples:** a `tilt_valid` arriving after the snapshot updates the hold registers only. It affects the next frame, not the update in flight.
- **Simultaneous events:** if `tilt_valid` and the edge occur in the same cycle, the snapshot takes the old hold value.
- **Reset:**
  - Reset overrides everything in the same clock.
  - The FSM goes to IDLE, position to (320, 240), `moving`=0, `se_d`=0, hold registers to 0.
  - A reset asserted during CALC or APPLY discards that update.
- **Output width:** `accel_x[31:10]` and `accel_y[31:9]` are always 0.

## Timing
- **Reset values:** `accel_x`=320, `accel_y`=240, `moving`=0.
- **Latency:** with the edge detected in cycle N, CALC runs in N+1 and APPLY in N+2. New outputs are visible from N+3.
- **Frame rate:**
  - Exactly one update per `screenEnd` rising edge, regardless of how long `screenEnd` stays high.
  - No update occurs without an edge.
- **Output stability:** outputs are registered and change only at the end of APPLY, or on reset. They are stable for the VGA controller's latch at the falling edge of `screenEnd`, because blanking is far longer than 3 cycles.
- **Per-axis behaviour:** both axes update in the same cycle. There is no cross-axis interaction.

## Test plan
- **Reset:** assert `reset` for 2 cycles → `accel_x`=320, `accel_y`=240, `moving`=0. Outputs stay unchanged across frames while `tilt_valid` is never pulsed.
- **Normal motion:** game_state=1, `tilt_x`=+200, `tilt_y`=−10, then 3 `screenEnd` pulses.
  - Expected vx=+8 (11 capped at 8) and vy=0 (within deadzone).
  - → `accel_x`=344, `accel_y`=240, `moving`=1. Each change appears exactly 3 cycles after the edge.
- **Clamping and mode change:**
  - `tilt_x`=+2047 with game_state=1 for 50 frames → `accel_x` saturates at 619.
  - Then switch to game_state=3 → `accel_x` rises to 627, then 629, and holds.
  - `tilt_y`=−2048 → `accel_y` decreases by 8 per frame and stops at 10.
- **Edge detect and sample timing:**
  - Hold `screenEnd` high for 100 cycles → exactly one update.
  - Pulse `tilt_valid` with a new value in the CALC cycle → the current update uses the old tilt and the next frame uses the new one.
- **Reset mid-update and start screen:**
  - Assert `reset` in the APPLY cycle → next cycle shows 320/240 and no increment.
  - With game_state=0 and any tilt → position stays pinned at 320/240 and `moving`=0.
